// File: rtl/picobus_loader.sv
// picobus_loader: streams a byte-wide program image into memory over the
// picorv32 native memory interface. It packs bytes little-endian into words
// and can read each word back to check it. The core is held in reset until
// the whole image has been written.
module picobus_loader #(
    parameter logic [31:0] BASE_ADDR      = 32'h0001_0000,
    parameter logic [31:0] MAX_BYTES      = 32'h0003_0000,
    parameter logic        VERIFY         = 1'b1,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        mem_valid,
    output logic        mem_instr,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        cpu_resetn,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  error_code,
    output logic [15:0] word_count
);

    localparam int          TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [31:0] LIMIT_ADDR = BASE_ADDR + MAX_BYTES;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_READ,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        state_reg, state_next;
    logic [31:0]   addr_reg;
    logic [31:0]   wdata_reg;
    logic [3:0]    wstrb_reg;
    logic [1:0]    idx_reg;
    logic          last_reg;
    logic [1:0]    err_code_reg;
    logic [15:0]   word_count_reg;
    logic [TW-1:0] tmo_reg;

    logic          err_set;
    logic [1:0]    err_val;
    logic          word_next;
    logic          start_ok;
    logic          accept;
    logic          at_limit;
    logic          on_bus;
    logic          tmo_hit;
    logic          mismatch;
    logic [3:0]    lane_sel;
    logic [31:0]   sel_bits;
    logic [31:0]   lane_mask;

    // Byte-lane expansion: the lane being filled, and the lanes that hold
    // collected data (only those take part in the read-back compare).
    assign lane_sel = 4'b0001 << idx_reg;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign sel_bits[8*gi +: 8]  = {8{lane_sel[gi]}};
            assign lane_mask[8*gi +: 8] = {8{wstrb_reg[gi]}};
        end
    endgenerate

    assign on_bus   = (state_reg == S_WRITE) || (state_reg == S_READ);
    assign at_limit = (addr_reg + {30'd0, idx_reg}) == LIMIT_ADDR;
    assign accept   = (state_reg == S_COLLECT) && in_valid && !at_limit;
    assign start_ok = start && ((state_reg == S_IDLE) || (state_reg == S_DONE) ||
                                (state_reg == S_ERROR));
    assign tmo_hit  = tmo_reg == TW'(TIMEOUT_CYCLES - 1);
    assign mismatch = |((mem_rdata ^ wdata_reg) & lane_mask);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    // Next-state decode, plus error capture and word-advance strobes.
    always_comb begin
        state_next = state_reg;
        err_set    = 1'b0;
        err_val    = 2'b00;
        word_next  = 1'b0;
        case (state_reg)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) state_next = S_COLLECT;
            end
            S_COLLECT: begin
                if (in_valid && at_limit) begin
                    state_next = S_ERROR;
                    err_set    = 1'b1;
                    err_val    = 2'b11;
                end else if (accept && (idx_reg == 2'd3 || in_last)) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (mem_ready) begin
                    if (VERIFY)        state_next = S_READ;
                    else if (last_reg) state_next = S_DONE;
                    else begin
                        state_next = S_COLLECT;
                        word_next  = 1'b1;
                    end
                end else if (tmo_hit) begin
                    state_next = S_ERROR;
                    err_set    = 1'b1;
                    err_val    = 2'b01;
                end
            end
            S_READ: begin
                if (mem_ready) begin
                    if (mismatch) begin
                        state_next = S_ERROR;
                        err_set    = 1'b1;
                        err_val    = 2'b10;
                    end else if (last_reg) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_COLLECT;
                        word_next  = 1'b1;
                    end
                end else if (tmo_hit) begin
                    state_next = S_ERROR;
                    err_set    = 1'b1;
                    err_val    = 2'b01;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: address, word assembly, counters and error code.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg       <= 32'd0;
            wdata_reg      <= 32'd0;
            wstrb_reg      <= 4'd0;
            idx_reg        <= 2'd0;
            last_reg       <= 1'b0;
            err_code_reg   <= 2'b00;
            word_count_reg <= 16'd0;
            tmo_reg        <= '0;
        end else begin
            if (start_ok) begin
                addr_reg       <= BASE_ADDR;
                wdata_reg      <= 32'd0;
                wstrb_reg      <= 4'd0;
                idx_reg        <= 2'd0;
                last_reg       <= 1'b0;
                err_code_reg   <= 2'b00;
                word_count_reg <= 16'd0;
            end
            if (accept) begin
                wdata_reg <= (wdata_reg & ~sel_bits) | ({4{in_data}} & sel_bits);
                wstrb_reg <= wstrb_reg | lane_sel;
                idx_reg   <= idx_reg + 2'd1;
                if (in_last) last_reg <= 1'b1;
            end
            if (state_reg == S_WRITE && mem_ready)
                word_count_reg <= word_count_reg + 16'd1;
            if (word_next) begin
                addr_reg  <= addr_reg + 32'd4;
                wdata_reg <= 32'd0;
                wstrb_reg <= 4'd0;
                idx_reg   <= 2'd0;
            end
            if (err_set) err_code_reg <= err_val;
            // The wait counter restarts whenever a new transaction begins.
            if (on_bus && state_next == state_reg) tmo_reg <= tmo_reg + TW'(1);
            else                                   tmo_reg <= '0;
        end
    end

    assign mem_valid  = on_bus;
    assign mem_instr  = 1'b0;
    assign mem_addr   = addr_reg;
    assign mem_wdata  = wdata_reg;
    assign mem_wstrb  = (state_reg == S_WRITE) ? wstrb_reg : 4'd0;
    assign in_ready   = (state_reg == S_COLLECT) && !at_limit;
    assign cpu_resetn = (state_reg == S_DONE);
    assign busy       = (state_reg == S_COLLECT) || on_bus;
    assign done       = (state_reg == S_DONE);
    assign error      = (state_reg == S_ERROR);
    assign error_code = err_code_reg;
    assign word_count = word_count_reg;

endmodule
